sseg_rx: RTL

SSEG_RX -- requirements
Module: sseg_rx

---
 rtl/sseg_rx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sseg_rx.sv
// Serial frame receiver with synchronized sclk/sclrn/sout/EN and frame-length checking.
// Optional 7-segment decode outputs are enabled by defining SSEG_RX_DECODE_EN.
module sseg_rx #(
  parameter int unsigned BIT_WIDTH = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 sclk,
  input  logic                                 sclrn,
  input  logic                                 sout,
  input  logic                                 EN,
  output logic [BIT_WIDTH-1:0]                 par_out,
  output logic                                 frame_valid,
  output logic                                 frame_err,
  output logic                                 busy,
  output logic [$clog2(BIT_WIDTH+2)-1:0]       bit_cnt
`ifdef SSEG_RX_DECODE_EN
  ,
  output logic [31:0]                          hexs,
  output logic [7:0]                           points,
  output logic [7:0]                           hex_ok
`endif
);

  localparam int unsigned CW = $clog2(BIT_WIDTH + 2);
  localparam logic [CW-1:0] FULL = CW'(BIT_WIDTH);
  localparam logic [CW-1:0] SAT  = CW'(BIT_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state_q, state_d;

  // Synchronizer order: {sclk, sclrn, sout, EN}
  logic [3:0] sync_1, sync_2;
  logic       sclk_prev, en_prev;
  logic       sclk_rise, en_rise, clr, sdata;

  logic [BIT_WIDTH-1:0] shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1    <= '0;
      sync_2    <= '0;
      sclk_prev <= 1'b0;
      en_prev   <= 1'b0;
    end else begin
      sync_1    <= {sclk, sclrn, sout, EN};
      sync_2    <= sync_1;
      sclk_prev <= sync_2[3];
      en_prev   <= sync_2[0];
    end
  end

  assign sclk_rise = sync_2[3] & ~sclk_prev;
  assign en_rise   = sync_2[0] & ~en_prev;
  assign clr       = ~sync_2[2];
  assign sdata     = sync_2[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, SHIFT: begin
          if (en_rise)        state_d = DONE;
          else if (sclk_rise) state_d = SHIFT;
        end
        DONE:    state_d = sclk_rise ? SHIFT : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q == SHIFT);

`ifdef SSEG_RX_DECODE_EN
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    r = '0;
    case (seg)
      7'h3F: r = 5'h10;  7'h06: r = 5'h11;  7'h5B: r = 5'h12;  7'h4F: r = 5'h13;
      7'h66: r = 5'h14;  7'h6D: r = 5'h15;  7'h7D: r = 5'h16;  7'h07: r = 5'h17;
      7'h7F: r = 5'h18;  7'h6F: r = 5'h19;  7'h77: r = 5'h1A;  7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;  7'h5E: r = 5'h1D;  7'h79: r = 5'h1E;  7'h71: r = 5'h1F;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [63:0] dec_src;
  logic [31:0] dec_hexs;
  logic [7:0]  dec_points, dec_ok;
  logic [4:0]  dec_r;

  assign dec_src = 64'(shreg);

  // Decode the pending shift register so it can be latched in the same cycle as par_out.
  always_comb begin
    dec_hexs   = '0;
    dec_points = '0;
    dec_ok     = '0;
    dec_r      = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      dec_r            = seg_decode(~dec_src[8*i +: 7]);
      dec_hexs[4*i +: 4] = dec_r[3:0];
      dec_ok[i]        = dec_r[4];
      dec_points[i]    = ~dec_src[8*i + 7];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      par_out     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
`ifdef SSEG_RX_DECODE_EN
      hexs        <= '0;
      points      <= '0;
      hex_ok      <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (clr) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else begin
        if (sclk_rise)
          shreg <= {shreg[BIT_WIDTH-2:0], sdata};
        if (state_q == DONE) begin
          if (bit_cnt == FULL) begin
            par_out     <= shreg;
            frame_valid <= 1'b1;
`ifdef SSEG_RX_DECODE_EN
            hexs        <= dec_hexs;
            points      <= dec_points;
            hex_ok      <= dec_ok;
`endif
          end else begin
            frame_err <= 1'b1;
          end
          // An sclk rise during DONE is the first bit of the next frame.
          bit_cnt <= sclk_rise ? CW'(1) : '0;
        end else if (sclk_rise) begin
          bit_cnt <= (bit_cnt == SAT) ? SAT : bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule
